// File: rtl/spi_regbank_pkg.sv
// Shared constants for the SPI register bank: register map, fast command codes
// and the fixed counts of event and snapshot registers.
package spi_regbank_pkg;

  // Register map
  localparam int ADDR_ID        = 0;
  localparam int ADDR_CTRL      = 1;
  localparam int ADDR_STICKY    = 2;
  localparam int ADDR_MASK      = 3;
  localparam int ADDR_SNAP_BASE = 4;
  localparam int ADDR_CFG_BASE  = 8;

  localparam int NUM_EVT  = 8;
  localparam int NUM_SNAP = 4;

  // Fast command codes; any other code is a no-op
  typedef enum logic [5:0] {
    FC_NOP        = 6'h00,
    FC_SOFT_RST   = 6'h01,
    FC_CLR_STICKY = 6'h02,
    FC_SNAPSHOT   = 6'h03,
    FC_TRIGGER    = 6'h04
  } fastcmd_e;

endpackage

// File: rtl/spi_regbank_evt_sticky.sv
// Event capture: rising-edge detector on evt_i, sticky flags where a set beats
// a clear in the same cycle, and a registered masked interrupt.
module evt_sticky
  import spi_regbank_pkg::*;
(
  input  logic               clk,
  input  logic               nrst,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [NUM_EVT-1:0] clr_i,
  input  logic [NUM_EVT-1:0] mask_i,
  output logic [NUM_EVT-1:0] sticky_o,
  output logic               irq_o
);

  logic [NUM_EVT-1:0] evt_prev_q;
  logic [NUM_EVT-1:0] sticky_q, sticky_d;
  logic [NUM_EVT-1:0] evt_rise;
  logic               irq_q, irq_d;

  // Edge detect, set-over-clear sticky update, masked interrupt reduce
  always_comb begin
    evt_rise = evt_i & ~evt_prev_q;
    sticky_d = (sticky_q & ~clr_i) | evt_rise;
    irq_d    = |(sticky_q & mask_i);
  end

  // Event history, sticky flags and interrupt flops; history is only cleared by nrst
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      evt_prev_q <= '0;
      sticky_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      evt_prev_q <= evt_i;
      sticky_q   <= sticky_d;
      irq_q      <= irq_d;
    end
  end

  assign sticky_o = sticky_q;
  assign irq_o    = irq_q;

endmodule

// File: rtl/spi_regbank.sv
// Register bank behind the SPI register slave: ID, CTRL, STICKY (W1C), MASK,
// four snapshot registers of hw_i and NUM_CFG config registers, plus fast
// commands (soft reset, sticky clear, atomic snapshot, trigger pulse).
//
// Bus protocol: wr_vld and fastcmd_vld are single-cycle strobes with no
// back-pressure; reg_addr/wr_data (resp. fastcmd) are valid in the strobe
// cycle. When both strobes coincide the write is applied first and the fast
// command second, so SOFT_RST overrides the write. rd_data always reflects
// reg_addr of the previous cycle.
module spi_regbank
  import spi_regbank_pkg::*;
#(
  parameter int          ADDR_W   = 6,
  parameter int          REG_W    = 16,
  parameter int          NUM_CFG  = 8,
  parameter logic [63:0] ID_VALUE = 16'hA55A
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [ADDR_W-1:0]        reg_addr,
  input  logic [REG_W-1:0]         wr_data,
  input  logic                     wr_vld,
  output logic [REG_W-1:0]         rd_data,
  output logic [7:0]               status,
  input  logic [5:0]               fastcmd,
  input  logic                     fastcmd_vld,
  output logic [REG_W-1:0]         ctrl_o,
  output logic [NUM_CFG*REG_W-1:0] cfg_o,
  input  logic [4*REG_W-1:0]       hw_i,
  input  logic [7:0]               evt_i,
  output logic                     irq_o,
  output logic                     trig_o
);

  localparam logic [REG_W-1:0] ID_R = REG_W'(ID_VALUE);

  logic [REG_W-1:0]   ctrl_q, ctrl_d;
  logic [REG_W-1:0]   mask_q, mask_d;
  logic [REG_W-1:0]   cfg_q  [NUM_CFG];
  logic [REG_W-1:0]   cfg_d  [NUM_CFG];
  logic [REG_W-1:0]   snap_q [NUM_SNAP];
  logic [REG_W-1:0]   snap_d [NUM_SNAP];
  logic [REG_W-1:0]   rd_q, rd_d;
  logic               trig_q, trig_d;
  logic [NUM_EVT-1:0] sticky;
  logic [NUM_EVT-1:0] sticky_clr;
  int                 addr_n;
  logic               fc_soft, fc_clr, fc_snap, fc_trig;

  // Address and fast command decode
  always_comb begin
    addr_n  = int'(reg_addr);
    fc_soft = fastcmd_vld && (fastcmd == FC_SOFT_RST);
    fc_clr  = fastcmd_vld && (fastcmd == FC_CLR_STICKY);
    fc_snap = fastcmd_vld && (fastcmd == FC_SNAPSHOT);
    fc_trig = fastcmd_vld && (fastcmd == FC_TRIGGER);
  end

  // Register next state: bus write first, then capture, then soft reset overrides
  always_comb begin
    ctrl_d = ctrl_q;
    mask_d = mask_q;
    cfg_d  = cfg_q;
    snap_d = snap_q;
    trig_d = fc_trig;
    if (wr_vld && addr_n == ADDR_CTRL) ctrl_d = wr_data;
    if (wr_vld && addr_n == ADDR_MASK) mask_d = wr_data;
    for (int k = 0; k < NUM_CFG; k++) begin
      if (wr_vld && addr_n == ADDR_CFG_BASE + k) cfg_d[k] = wr_data;
    end
    // Command snapshot and auto-snapshot merge into a single capture
    if (fc_snap || ctrl_q[0]) begin
      for (int i = 0; i < NUM_SNAP; i++) snap_d[i] = hw_i[i*REG_W +: REG_W];
    end
    if (fc_soft) begin
      ctrl_d = '0;
      mask_d = '0;
      for (int k = 0; k < NUM_CFG; k++) cfg_d[k] = '0;
      for (int i = 0; i < NUM_SNAP; i++) snap_d[i] = '0;
    end
  end

  // Sticky clear bits from a W1C write and from the clearing fast commands
  always_comb begin
    sticky_clr = '0;
    if (wr_vld && addr_n == ADDR_STICKY) sticky_clr = wr_data[NUM_EVT-1:0];
    if (fc_soft || fc_clr) sticky_clr = '1;
  end

  // Read mux; unmapped addresses return zero
  always_comb begin
    rd_d = '0;
    if (addr_n == ADDR_ID)     rd_d = ID_R;
    if (addr_n == ADDR_CTRL)   rd_d = ctrl_q;
    if (addr_n == ADDR_STICKY) rd_d = REG_W'(sticky);
    if (addr_n == ADDR_MASK)   rd_d = mask_q;
    for (int i = 0; i < NUM_SNAP; i++) begin
      if (addr_n == ADDR_SNAP_BASE + i) rd_d = snap_q[i];
    end
    for (int k = 0; k < NUM_CFG; k++) begin
      if (addr_n == ADDR_CFG_BASE + k) rd_d = cfg_q[k];
    end
  end

  // Register state, read data and trigger pulse
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ctrl_q <= '0;
      mask_q <= '0;
      rd_q   <= '0;
      trig_q <= 1'b0;
      for (int k = 0; k < NUM_CFG; k++) cfg_q[k] <= '0;
      for (int i = 0; i < NUM_SNAP; i++) snap_q[i] <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      mask_q <= mask_d;
      rd_q   <= rd_d;
      trig_q <= trig_d;
      for (int k = 0; k < NUM_CFG; k++) cfg_q[k] <= cfg_d[k];
      for (int i = 0; i < NUM_SNAP; i++) snap_q[i] <= snap_d[i];
    end
  end

  evt_sticky u_evt_sticky (
    .clk      (clk),
    .nrst     (nrst),
    .evt_i    (evt_i),
    .clr_i    (sticky_clr),
    .mask_i   (mask_q[NUM_EVT-1:0]),
    .sticky_o (sticky),
    .irq_o    (irq_o)
  );

  // Flatten config registers onto the output bus
  always_comb begin
    cfg_o = '0;
    for (int k = 0; k < NUM_CFG; k++) cfg_o[k*REG_W +: REG_W] = cfg_q[k];
  end

  assign ctrl_o  = ctrl_q;
  assign rd_data = rd_q;
  assign status  = sticky;
  assign trig_o  = trig_q;

endmodule

// File: tb/tb_spi_regbank.sv
// Directed bench for spi_regbank with hand-computed expectations.
module tb_spi_regbank;
  import spi_regbank_pkg::*;

  localparam int ADDR_W  = 6;
  localparam int REG_W   = 16;
  localparam int NUM_CFG = 8;

  logic                     clk = 1'b0;
  logic                     nrst = 1'b0;
  logic [ADDR_W-1:0]        reg_addr = '0;
  logic [REG_W-1:0]         wr_data = '0;
  logic                     wr_vld = 1'b0;
  logic [REG_W-1:0]         rd_data;
  logic [7:0]               status;
  logic [5:0]               fastcmd = '0;
  logic                     fastcmd_vld = 1'b0;
  logic [REG_W-1:0]         ctrl_o;
  logic [NUM_CFG*REG_W-1:0] cfg_o;
  logic [4*REG_W-1:0]       hw_i = '0;
  logic [7:0]               evt_i = '0;
  logic                     irq_o;
  logic                     trig_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [REG_W-1:0] exp_q[$];

  spi_regbank #(.ADDR_W(ADDR_W), .REG_W(REG_W), .NUM_CFG(NUM_CFG), .ID_VALUE(16'hA55A)) dut (
    .clk(clk), .nrst(nrst), .reg_addr(reg_addr), .wr_data(wr_data), .wr_vld(wr_vld),
    .rd_data(rd_data), .status(status), .fastcmd(fastcmd), .fastcmd_vld(fastcmd_vld),
    .ctrl_o(ctrl_o), .cfg_o(cfg_o), .hw_i(hw_i), .evt_i(evt_i), .irq_o(irq_o), .trig_o(trig_o)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [REG_W-1:0] d);
    reg_addr = ADDR_W'(a);
    wr_data  = d;
    wr_vld   = 1'b1;
    tick();
    wr_vld   = 1'b0;
  endtask

  task automatic fc(input logic [5:0] c);
    fastcmd     = c;
    fastcmd_vld = 1'b1;
    tick();
    fastcmd_vld = 1'b0;
  endtask

  task automatic rd_expect(input string tag, input int a, input logic [REG_W-1:0] e);
    exp_q.push_back(e);
    reg_addr = ADDR_W'(a);
    tick();
    check(tag, rd_data, exp_q.pop_front());
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_rd", rd_data, 0);
    check("rst_status", status, 0);
    check("rst_ctrl", ctrl_o, 0);
    check("rst_cfg", cfg_o, 0);
    check("rst_irq", irq_o, 0);
    check("rst_trig", trig_o, 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    reg_addr = 6'd0;
    check("pre_id", rd_data, 0);
    tick();
    check("id_read", rd_data, 16'hA55A);

    // Config write and readback
    wr(10, 16'h1234);
    check("cfg2_out", cfg_o[47:32], 16'h1234);
    rd_expect("cfg2_rd", 10, 16'h1234);

    // Writes to read-only and unmapped addresses
    wr(0, 16'hFFFF);
    wr(20, 16'hFFFF);
    rd_expect("id_after_wr", 0, 16'hA55A);
    rd_expect("unmapped_rd", 20, 16'h0000);
    check("cfg_unchanged", cfg_o, 128'h0000_0000_0000_0000_0000_1234_0000_0000);
    check("ctrl_unchanged", ctrl_o, 0);

    // Event edge, sticky and interrupt latency
    wr(3, 16'h0008);
    evt_i = 8'h08;
    tick();
    check("evt3_status", status, 8'h08);
    check("evt3_irq_lat", irq_o, 0);
    tick();
    check("evt3_irq", irq_o, 1);
    rd_expect("sticky_rd", 2, 16'h0008);

    // W1C collides with a fresh edge on the same bit: set wins
    evt_i = 8'h00;
    tick();
    evt_i = 8'h08;
    wr(2, 16'h0008);
    check("set_over_w1c", status, 8'h08);

    // Plain W1C clears; irq drops two cycles after the write
    wr(2, 16'h0008);
    check("w1c_status", status, 8'h00);
    check("w1c_irq_hold", irq_o, 1);
    tick();
    check("w1c_irq_drop", irq_o, 0);

    // Unmasked event sets status but not irq
    evt_i = 8'h28;
    tick();
    check("evt5_status", status, 8'h20);
    tick();
    check("evt5_irq", irq_o, 0);

    // Atomic snapshot, then hw_i changes do not disturb it
    hw_i = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
    fc(6'h03);
    hw_i = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    rd_expect("snap0", 4, 16'h000A);
    rd_expect("snap1", 5, 16'h000B);
    rd_expect("snap2", 6, 16'h000C);
    rd_expect("snap3", 7, 16'h000D);

    // Auto-snapshot follows hw_i every cycle
    wr(1, 16'h0001);
    check("ctrl_auto", ctrl_o, 16'h0001);
    hw_i = {16'h0077, 16'h0003, 16'h0002, 16'h5A5A};
    reg_addr = 6'd4;
    tick();
    rd_expect("auto_snap0", 4, 16'h5A5A);
    rd_expect("auto_snap3", 7, 16'h0077);
    hw_i[15:0] = 16'h1111;
    reg_addr = 6'd4;
    tick();
    rd_expect("auto_track", 4, 16'h1111);

    // Trigger: single pulse, then back-to-back pulses
    check("trig_idle", trig_o, 0);
    fc(6'h04);
    check("trig_hi", trig_o, 1);
    tick();
    check("trig_lo", trig_o, 0);
    fastcmd = 6'h04;
    fastcmd_vld = 1'b1;
    tick();
    check("trig_b2b_1", trig_o, 1);
    tick();
    fastcmd_vld = 1'b0;
    check("trig_b2b_2", trig_o, 1);
    tick();
    check("trig_b2b_end", trig_o, 0);

    // Unknown command is a no-op
    wr(1, 16'hFFFF);
    wr(8, 16'h0001);
    fc(6'h3F);
    check("nop_ctrl", ctrl_o, 16'hFFFF);
    check("nop_cfg0", cfg_o[15:0], 16'h0001);
    check("nop_cfg2", cfg_o[47:32], 16'h1234);
    check("nop_status", status, 8'h20);
    check("nop_trig", trig_o, 0);

    // Soft reset clears registers and sticky but not the edge history
    fc(6'h01);
    check("srst_ctrl", ctrl_o, 0);
    check("srst_cfg", cfg_o, 0);
    check("srst_status", status, 0);
    rd_expect("srst_ctrl_rd", 1, 16'h0000);
    rd_expect("srst_cfg0_rd", 8, 16'h0000);
    rd_expect("srst_mask_rd", 3, 16'h0000);
    rd_expect("srst_snap0_rd", 4, 16'h0000);
    rd_expect("srst_id_rd", 0, 16'hA55A);
    check("srst_no_spurious", status, 0);

    // Clear-sticky command
    evt_i = 8'h00;
    tick();
    evt_i = 8'h01;
    tick();
    check("clr_pre", status, 8'h01);
    fc(6'h02);
    check("clr_sticky", status, 8'h00);

    // Asynchronous reset drops a pending trigger and clears state
    wr(1, 16'h00F0);
    fastcmd = 6'h04;
    fastcmd_vld = 1'b1;
    tick();
    fastcmd_vld = 1'b0;
    check("arst_trig_pre", trig_o, 1);
    #2;
    nrst = 1'b0;
    #1;
    check("arst_trig", trig_o, 0);
    check("arst_ctrl", ctrl_o, 0);
    check("arst_rd", rd_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_regbank.md
# spi_regbank

Register bank that sits directly downstream of the SPI register slave and serves its register bus.
- Decodes register writes, fast commands and read addresses.
- Returns read data and an 8-bit status byte.
- Exposes control/config registers, snapshotted hardware inputs, sticky event flags with an interrupt, and a trigger pulse to the surrounding design.

## Interface
Parameters:
- ADDR_W, 6: register address width; must satisfy 8+NUM_CFG ≤ 2^ADDR_W.
- REG_W, 16: register width; a multiple of 8, from 8 to 64.
- NUM_CFG, 8: number of RW config registers, at addresses 8..8+NUM_CFG-1.
- ID_VALUE, 16'hA55A: read-only identification value, zero-extended or truncated to REG_W.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- reg_addr  in  ADDR_W  current register address from the SPI slave
- wr_data  in  REG_W  write data
- wr_vld  in  1  single-cycle write strobe; reg_addr is valid in the same cycle
- rd_data  out  REG_W  read data for reg_addr
- status  out  8  status byte shifted out at the start of every SPI frame
- fastcmd  in  6  fast command code
- fastcmd_vld  in  1  single-cycle fast command strobe
- ctrl_o  out  REG_W  CTRL register
- cfg_o  out  NUM_CFG*REG_W  config registers; cfg k occupies bits [k*REG_W +: REG_W]
- hw_i  in  4*REG_W  hardware values captured into the snapshot registers
- evt_i  in  8  event inputs, synchronous to clk
- irq_o  out  1  interrupt, level
- trig_o  out  1  one-cycle trigger pulse

## Operation
Register map (addresses ≥ 8+NUM_CFG read 0; writes to them are ignored):
- 0 ID: read-only, ID_VALUE.
- 1 CTRL: RW. CTRL[0]=1 enables auto-snapshot: hw_i is captured every cycle.
- 2 STICKY: low 8 bits are event flags, upper bits read 0. Write-1-to-clear.
- 3 MASK: RW; low 8 bits are used as the IRQ mask.
- 4..7 SNAP0..3: read-only captured copies of hw_i words 0..3.
- 8..: CFG0..CFG(NUM_CFG-1), RW.

Events:
- A rising edge on evt_i[b] (previous sample 0, current sample 1) sets STICKY[b].
- If a set and a W1C clear hit the same bit in the same cycle, the set wins.

Outputs derived from STICKY:
- irq_o is registered, equal to |(STICKY[7:0] & MASK[7:0]).
- status equals STICKY[7:0] straight from the flops.

Fast commands (code applied when fastcmd_vld=1; all other codes are no-ops):
- 0x00 NOP.
- 0x01 SOFT_RST: CTRL, MASK, CFG*, SNAP* and STICKY go to 0. The evt_i history flops are not cleared, so no spurious edge is detected.
- 0x02 CLR_STICKY: STICKY ← 0.
- 0x03 SNAPSHOT: all four SNAP registers capture hw_i in the same cycle (atomic).
- 0x04 TRIGGER: trig_o pulses.

Simultaneous events:
- wr_vld and fastcmd_vld together: apply the write first, then the fast command. SOFT_RST therefore wins on shared registers.
- SNAPSHOT while CTRL[0]=1: a single capture occurs.

## Timing
Reset values:
- rd_data, status, ctrl_o, cfg_o, irq_o, trig_o: all 0.
- All internal registers and the evt_i history: 0.

Latencies:
- Writes: register, ctrl_o and cfg_o update 1 cycle after wr_vld.
- Reads: rd_data is registered and equals map(reg_addr) from the previous cycle, so 1-cycle latency. The SPI slave samples rd_data at least half an SCLK after an address change; clk ≥ 8× SCLK guarantees this.
- Events: STICKY sets 1 cycle after the evt_i edge is sampled; irq_o follows 1 cycle later.
- trig_o: high exactly 1 cycle, in the cycle after fastcmd_vld with code 0x04. Back-to-back TRIGGER commands give back-to-back pulses.
- SNAP: updates 1 cycle after fastcmd_vld, or every cycle while CTRL[0]=1.
- A write to STICKY clears the bits that are 1 in wr_data[7:0]; the new STICKY is visible the next cycle.

Asynchronous nrst mid-transfer:
- All state clears immediately; no pulse or partial write survives.
- A pending trig_o drops.

## Structure
Shared package spi_regbank_pkg holds:
- Address constants: ADDR_ID=0, ADDR_CTRL=1, ADDR_STICKY=2, ADDR_MASK=3, ADDR_SNAP_BASE=4, ADDR_CFG_BASE=8.
- Fast command codes: FC_NOP, FC_SOFT_RST, FC_CLR_STICKY, FC_SNAPSHOT, FC_TRIGGER.
- Constants NUM_EVT=8 and NUM_SNAP=4.

Sub-module evt_sticky contains:
- evt_i edge detector.
- STICKY flops with set-over-clear priority.
- Mask AND-reduce and registered irq_o.

## Test plan
- Reset, then hold reg_addr=0 → rd_data=16'hA55A after 1 cycle; all outputs 0 before that.
- Write CFG2 (addr 10) = 16'h1234 → cfg_o[47:32]=16'h1234 the next cycle; addr 10 reads 16'h1234.
- Write to addr 0 or addr 20 → no register changes; addr 20 reads 0.
- evt_i[3] 0→1 with MASK=8'h08:
  - STICKY=8'h08, status=8'h08, irq_o=1.
  - W1C write of 16'h0008 together with a new evt_i[3] edge in the same cycle → STICKY stays 8'h08.
  - A plain W1C write of 16'h0008 → irq_o=0 two cycles later.
- hw_i={4 words 16'hA,B,C,D}, fastcmd 0x03 → SNAP0..3 read A,B,C,D; changing hw_i afterwards leaves them unchanged. Set CTRL[0]=1 → SNAP tracks hw_i every cycle.
- fastcmd 0x04 → trig_o high exactly 1 cycle.
- fastcmd 0x01 after CTRL=16'hFFFF and CFG0=1 → both read 0; ID still reads 16'hA55A.
- Unknown code 0x3F → no change.
